// File: rtl/alu_top.sv
// alu_top: FPGA top of the ALU lab design.
// Three level-sensitive buttons latch operand A, operand B and the opcode
// from a shared switch bank; the ALU result plus zero/carry flags drive the
// LEDs through an output register.
// Optional build macro: ALU_BTN_SYNC_EN adds a 2-flop synchronizer on each
// button bit (load latency +2 cycles; switch data sampled at the load edge).
module alu_top #(
    parameter int NB_DATA_OUT     = 10,
    parameter int NB_DATA_IN      = 8,
    parameter int NB_OP_CODE_IN   = 6,
    parameter int NB_INPUT_SELECT = 3
) (
    input  logic                       clock,
    input  logic                       i_rst,
    input  logic [NB_INPUT_SELECT-1:0] i_btn,
    input  logic [NB_DATA_IN-1:0]      i_sw_data,
    output logic [NB_DATA_OUT-1:0]     o_led
);

    localparam logic [NB_OP_CODE_IN-1:0] OP_ADD = 6'b100000;
    localparam logic [NB_OP_CODE_IN-1:0] OP_SUB = 6'b100010;
    localparam logic [NB_OP_CODE_IN-1:0] OP_AND = 6'b100100;
    localparam logic [NB_OP_CODE_IN-1:0] OP_OR  = 6'b100101;
    localparam logic [NB_OP_CODE_IN-1:0] OP_XOR = 6'b100110;
    localparam logic [NB_OP_CODE_IN-1:0] OP_SRA = 6'b000011;
    localparam logic [NB_OP_CODE_IN-1:0] OP_SRL = 6'b000010;
    localparam logic [NB_OP_CODE_IN-1:0] OP_NOR = 6'b100111;

    // LED value for the cleared state: opcode 0 yields ext = 0, so zero = 1.
    localparam logic [NB_DATA_OUT-1:0] LED_RST = {1'b1, 1'b0, {NB_DATA_IN{1'b0}}};

    logic [NB_INPUT_SELECT-1:0] btn_use;
    logic [NB_DATA_IN-1:0]      reg_a;
    logic [NB_DATA_IN-1:0]      reg_b;
    logic [NB_OP_CODE_IN-1:0]   reg_op;
    logic [NB_DATA_IN:0]        ext;
    logic [NB_DATA_IN-1:0]      sra_res;
    logic                       zero;
    logic                       carry;

`ifdef ALU_BTN_SYNC_EN
    logic [NB_INPUT_SELECT-1:0] btn_meta;
    logic [NB_INPUT_SELECT-1:0] btn_sync;

    // Two-flop synchronizer on each asynchronous push-button bit.
    always_ff @(posedge clock) begin
        if (i_rst) begin
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            btn_meta <= i_btn;
            btn_sync <= btn_meta;
        end
    end

    assign btn_use = btn_sync;
`else
    // Buttons are assumed clean and synchronous to clock.
    assign btn_use = i_btn;
`endif

    // Operand/opcode registers; a held button reloads every cycle.
    always_ff @(posedge clock) begin
        if (i_rst) begin
            reg_a  <= '0;
            reg_b  <= '0;
            reg_op <= '0;
        end else begin
            if (btn_use[0]) reg_a  <= i_sw_data;
            if (btn_use[1]) reg_b  <= i_sw_data;
            if (btn_use[2]) reg_op <= i_sw_data[NB_OP_CODE_IN-1:0];
        end
    end

    // Arithmetic shift uses the full operand B; shifts of width or more
    // saturate to the sign fill.
    assign sra_res = $unsigned($signed(reg_a) >>> reg_b);

    // ALU datapath: extended result plus flags.
    always_comb begin
        ext   = '0;
        carry = 1'b0;
        case (reg_op)
            OP_ADD: begin
                ext   = {1'b0, reg_a} + {1'b0, reg_b};
                carry = ext[NB_DATA_IN];
            end
            OP_SUB: begin
                ext   = {1'b0, reg_a} - {1'b0, reg_b};
                carry = ~ext[NB_DATA_IN];   // 1 when no borrow (A >= B)
            end
            OP_AND:  ext = {1'b0, reg_a & reg_b};
            OP_OR:   ext = {1'b0, reg_a | reg_b};
            OP_XOR:  ext = {1'b0, reg_a ^ reg_b};
            OP_SRA:  ext = {1'b0, sra_res};
            OP_SRL:  ext = {1'b0, reg_a >> reg_b};
            OP_NOR:  ext = {1'b0, ~(reg_a | reg_b)};
            default: ext = '0;
        endcase
        // Zero looks at all extended bits, so a carry-out alone is not zero.
        zero = ~|ext;
    end

    // LED output register, updated every cycle.
    always_ff @(posedge clock) begin
        if (i_rst) o_led <= LED_RST;
        else       o_led <= {zero, carry, ext[NB_DATA_IN-1:0]};
    end

endmodule

// File: tb/tb_alu_top.sv
// tb_alu_top: scoreboard bench for alu_top. Stimulus pushes expected LED
// values (with the cycle at which they must hold) into a queue; a monitor
// on the falling edge pops and compares. Expectations come from an
// arithmetic reference model of the ALU rules.
module tb_alu_top;

    logic       clock = 1'b0;
    logic       i_rst;
    logic [2:0] i_btn;
    logic [7:0] i_sw_data;
    logic [9:0] o_led;

    alu_top dut (
        .clock    (clock),
        .i_rst    (i_rst),
        .i_btn    (i_btn),
        .i_sw_data(i_sw_data),
        .o_led    (o_led)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         due;
        logic [9:0] exp;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    exp_t mon_e;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: compare every expectation whose due cycle has arrived.
    always @(negedge clock) begin
        while (sb.size() != 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            n_cmp++;
            if (o_led !== mon_e.exp) begin
                n_bad++;
                $display("FAIL %s: o_led=%h expected=%h", mon_e.tag, o_led, mon_e.exp);
            end
        end
    end

    // Reference model: LED word from operands and opcode by plain arithmetic.
    function automatic logic [9:0] ref_led(int a, int b, int op);
        int r;
        int sa;
        bit c;
        r = 0;
        c = 0;
        case (op)
            32: begin r = a + b; c = (r > 255); end
            34: begin r = (a - b + 512) % 512; c = (a >= b); end
            36: r = a & b;
            37: r = a | b;
            38: r = a ^ b;
            39: r = 255 - (a | b);
            3: begin
                if (b >= 8) r = (a >= 128) ? 255 : 0;
                else begin
                    sa = (a >= 128) ? a - 256 : a;
                    r  = (sa >>> b) & 255;
                end
            end
            2: r = (b >= 8) ? 0 : (a >> b);
            default: r = 0;
        endcase
        return {(r == 0), c, 8'(r % 256)};
    endfunction

    task automatic push(int lat, logic [9:0] exp, string tag);
        exp_t e;
        e.due = cyc + lat;
        e.exp = exp;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // One button press; switch data held two extra cycles so a synchronized
    // build still samples the intended value.
    task automatic press(logic [2:0] btn, logic [7:0] sw);
        @(negedge clock);
        i_btn     = btn;
        i_sw_data = sw;
        @(negedge clock);
        i_btn = 3'b000;
        repeat (2) @(negedge clock);
    endtask

    task automatic run_op(int a, int b, int op, string tag);
        logic [7:0] opsw;
        opsw = 8'(op);
        opsw[7:6] = 2'($urandom_range(0, 3));   // ignored upper bits
        press(3'b001, 8'(a));
        press(3'b010, 8'(b));
        press(3'b100, opsw);
        push(4, ref_led(a, b, op), tag);
        repeat (6) @(negedge clock);
    endtask

    int ops[9] = '{32, 34, 36, 37, 38, 3, 2, 39, 63};

    initial begin
        i_rst     = 1'b1;
        i_btn     = 3'b000;
        i_sw_data = 8'h00;
        repeat (3) @(negedge clock);
        push(0, 10'h200, "reset_hold");
        repeat (2) @(negedge clock);
        i_rst = 1'b0;
        push(3, 10'h200, "after_reset");
        repeat (4) @(negedge clock);

        run_op(8'h03, 8'h04, 32, "add");
        run_op(8'hFF, 8'h01, 32, "add_carry");
        run_op(8'h80, 8'h80, 32, "add_wrap_not_zero");
        run_op(8'h04, 8'h02, 34, "sub_pos");
        run_op(8'h02, 8'h04, 34, "sub_borrow");
        run_op(8'h03, 8'h03, 34, "sub_equal");
        run_op(8'h04, 8'h01, 36, "and");
        run_op(8'h04, 8'h01, 37, "or");
        run_op(8'h04, 8'h01, 38, "xor");
        run_op(8'h04, 8'h01, 39, "nor");
        run_op(8'h04, 8'h01, 2,  "srl");
        run_op(8'h80, 8'h01, 3,  "sra");
        run_op(8'h80, 8'h09, 2,  "srl_big");
        run_op(8'h80, 8'h0A, 3,  "sra_big");
        run_op(8'h5A, 8'hC3, 63, "undef_op");

        // Simultaneous A/B load, then ADD.
        press(3'b011, 8'h05);
        press(3'b100, 8'h20);
        push(4, 10'h00A, "btn_together");
        repeat (6) @(negedge clock);

        // Reset in the middle of a live result.
        run_op(8'hFF, 8'h01, 32, "pre_reset");
        @(negedge clock);
        i_rst = 1'b1;
        push(1, 10'h200, "rst_mid");
        repeat (2) @(negedge clock);
        // Reset must win over buttons in the same cycle.
        i_btn     = 3'b111;
        i_sw_data = 8'hFF;
        @(negedge clock);
        i_btn = 3'b000;
        i_rst = 1'b0;
        push(4, 10'h200, "rst_priority");
        repeat (6) @(negedge clock);

        // Randomized operations.
        for (int i = 0; i < 40; i++) begin
            run_op(int'($urandom_range(0, 255)),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                               : int'($urandom_range(0, 10)),
                   ops[$urandom_range(0, 8)], "rand");
        end

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clock);
        if (sb.size() != 0) begin
            $display("FAIL drain: pending=%0d expected=0", sb.size());
            n_bad += sb.size();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
